// File: rtl/operand_fetch.sv
// Operand fetch stage: register file with write-through bypass feeding a
// single-entry output register toward the ALU with a valid/ready handshake.
module operand_fetch #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      operation,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [4:0]      out_rd
);

    logic [XLEN-1:0] regFile_q [NREGS];

    logic            outValid_q,  outValid_d;
    logic [3:0]      operation_q, operation_d;
    logic [XLEN-1:0] operand1_q,  operand1_d;
    logic [XLEN-1:0] operand2_q,  operand2_d;
    logic [4:0]      outRd_q,     outRd_d;

    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic            inReady;
    logic            accept;

    // x0 is hardwired to zero, so writes to it are simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile_q[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regFile_q[wb_rd] <= wb_data;
        end
    end

    // A same-cycle writeback overrides the stored value so the consumer never
    // sees a stale register.
    always_comb begin
        rs1Data = regFile_q[rs1];
        rs2Data = regFile_q[rs2];
        if (wb_en && (wb_rd == rs1)) begin
            rs1Data = wb_data;
        end
        if (wb_en && (wb_rd == rs2)) begin
            rs2Data = wb_data;
        end
        if (rs1 == 5'd0) begin
            rs1Data = '0;
        end
        if (rs2 == 5'd0) begin
            rs2Data = '0;
        end
    end

    assign inReady = !outValid_q || out_ready;
    assign accept  = in_valid && inReady && !flush;

    // Held payload is only replaced on acceptance; flush clears valid alone.
    always_comb begin
        outValid_d  = outValid_q;
        operation_d = operation_q;
        operand1_d  = operand1_q;
        operand2_d  = operand2_q;
        outRd_d     = outRd_q;
        if (flush) begin
            outValid_d = 1'b0;
        end else if (accept) begin
            outValid_d  = 1'b1;
            operation_d = alu_op;
            operand1_d  = rs1Data;
            operand2_d  = use_imm ? imm : rs2Data;
            outRd_d     = rd;
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q  <= 1'b0;
            operation_q <= '0;
            operand1_q  <= '0;
            operand2_q  <= '0;
            outRd_q     <= '0;
        end else begin
            outValid_q  <= outValid_d;
            operation_q <= operation_d;
            operand1_q  <= operand1_d;
            operand2_q  <= operand2_d;
            outRd_q     <= outRd_d;
        end
    end

    assign in_ready  = inReady;
    assign out_valid = outValid_q;
    assign operation = operation_q;
    assign operand1  = operand1_q;
    assign operand2  = operand2_q;
    assign out_rd    = outRd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios followed by random
// traffic, checked against an architectural register/queue model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic [63:0] imm;
    logic        use_imm;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  operation;
    logic [63:0] operand1, operand2;
    logic [4:0]  out_rd;

    typedef struct {
        logic        inValid;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic [63:0] imm;
        logic        useImm;
        logic        wbEn;
        logic [4:0]  wbRd;
        logic [63:0] wbData;
        logic        flush;
        logic        outReady;
        logic        reset;
    } stimT;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a, b;
        logic [4:0]  rd;
    } expT;

    logic [63:0] regs [32];
    expT         expQ [$];
    logic        modelValid = 1'b0;
    logic        monitorOn  = 1'b0;
    int          checks = 0;
    int          errors = 0;

    operand_fetch #(.XLEN(64), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .imm(imm),
        .use_imm(use_imm), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .operation(operation), .operand1(operand1), .operand2(operand2),
        .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    function automatic stimT idleStim();
        stimT s;
        s.inValid = 1'b0; s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.op = '0;
        s.imm = '0; s.useImm = 1'b0; s.wbEn = 1'b0; s.wbRd = '0;
        s.wbData = '0; s.flush = 1'b0; s.outReady = 1'b1; s.reset = 1'b0;
        return s;
    endfunction

    function automatic stimT issueStim(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] d, input logic [3:0] op);
        stimT s = idleStim();
        s.inValid = 1'b1; s.rs1 = a; s.rs2 = b; s.rd = d; s.op = op;
        return s;
    endfunction

    function automatic stimT wbStim(input logic [4:0] r, input logic [63:0] v);
        stimT s = idleStim();
        s.wbEn = 1'b1; s.wbRd = r; s.wbData = v;
        return s;
    endfunction

    // Architectural read: x0 is zero, a same-cycle writeback is visible.
    function automatic logic [63:0] modelRead(input logic [4:0] idx, input stimT s);
        if (idx == 5'd0) return 64'd0;
        if (s.wbEn && s.wbRd == idx) return s.wbData;
        return regs[idx];
    endfunction

    // Drives one cycle of inputs, records any expected issue, then advances
    // the model across the clock edge.
    task automatic applyStimulus(input stimT s);
        logic acc;
        logic nextValid;
        expT  e;
        reset = s.reset; in_valid = s.inValid; rs1 = s.rs1; rs2 = s.rs2;
        rd = s.rd; alu_op = s.op; imm = s.imm; use_imm = s.useImm;
        wb_en = s.wbEn; wb_rd = s.wbRd; wb_data = s.wbData;
        flush = s.flush; out_ready = s.outReady;
        acc = !s.reset && !s.flush && s.inValid && (!modelValid || s.outReady);
        if (acc) begin
            e.op = s.op;
            e.a  = modelRead(s.rs1, s);
            e.b  = s.useImm ? s.imm : modelRead(s.rs2, s);
            e.rd = s.rd;
            expQ.push_back(e);
        end
        if (s.reset || s.flush) nextValid = 1'b0;
        else if (acc) nextValid = 1'b1;
        else if (modelValid && s.outReady) nextValid = 1'b0;
        else nextValid = modelValid;
        @(posedge clk);
        #1;
        if (s.reset) begin
            for (int i = 0; i < 32; i++) regs[i] = 64'd0;
            expQ.delete();
        end else begin
            if (s.wbEn && s.wbRd != 5'd0) regs[s.wbRd] = s.wbData;
            if (s.flush) expQ.delete();
        end
        modelValid = nextValid;
    endtask

    // After a reset edge every output register must read zero.
    task automatic checkOutput(input string name);
        checks++;
        if (out_valid !== 1'b0 || operation !== 4'd0 || operand1 !== 64'd0 ||
            operand2 !== 64'd0 || out_rd !== 5'd0) begin
            errors++;
            $display("[TB] FAIL %s: got v=%b op=%h a=%h b=%h rd=%h, expected all zero",
                     name, out_valid, operation, operand1, operand2, out_rd);
        end
    endtask

    // Monitor: compares the presented instruction with the oldest expected
    // entry every cycle it is valid and retires it on a completed handshake.
    always @(negedge clk) begin
        if (monitorOn) begin
            checks++;
            if (out_valid !== modelValid) begin
                errors++;
                $display("[TB] FAIL out_valid: got %b expected %b", out_valid, modelValid);
            end
            checks++;
            if (in_ready !== (!modelValid || out_ready)) begin
                errors++;
                $display("[TB] FAIL in_ready: got %b expected %b", in_ready, !modelValid || out_ready);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_output: got op=%h a=%h b=%h rd=%h, expected none",
                             operation, operand1, operand2, out_rd);
                end else begin
                    if (operation !== expQ[0].op || operand1 !== expQ[0].a ||
                        operand2 !== expQ[0].b || out_rd !== expQ[0].rd) begin
                        errors++;
                        $display("[TB] FAIL payload: got op=%h a=%h b=%h rd=%h expected op=%h a=%h b=%h rd=%h",
                                 operation, operand1, operand2, out_rd,
                                 expQ[0].op, expQ[0].a, expQ[0].b, expQ[0].rd);
                    end
                    if (out_ready && !flush && !reset) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        stimT s;
        for (int i = 0; i < 32; i++) regs[i] = 64'd0;
        s = idleStim();
        s.reset = 1'b1;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; wb_en = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(s);
        applyStimulus(s);
        checkOutput("reset_outputs");
        monitorOn = 1'b1;

        // Plain register operands
        applyStimulus(wbStim(5'd5, 64'hFFFF));
        applyStimulus(wbStim(5'd6, 64'h2));
        applyStimulus(issueStim(5'd5, 5'd6, 5'd1, 4'b0000));
        applyStimulus(idleStim());

        // Same-cycle writeback bypass
        s = issueStim(5'd7, 5'd5, 5'd2, 4'b0001);
        s.wbEn = 1'b1; s.wbRd = 5'd7; s.wbData = 64'hABCD;
        applyStimulus(s);
        applyStimulus(idleStim());

        // x0 stays zero; immediate as operand2; undecoded opcode passes through
        applyStimulus(wbStim(5'd0, 64'h1234));
        s = issueStim(5'd0, 5'd6, 5'd3, 4'b1110);
        s.useImm = 1'b1; s.imm = 64'h10;
        applyStimulus(s);
        applyStimulus(idleStim());

        // Stall three cycles, second instruction waits then issues
        s = issueStim(5'd5, 5'd7, 5'd4, 4'b0010);
        s.outReady = 1'b0;
        applyStimulus(s);
        s = issueStim(5'd6, 5'd5, 5'd8, 4'b0011);
        s.outReady = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        s.outReady = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(idleStim());

        // Flush drops held and incoming instruction, writeback still lands
        s = issueStim(5'd5, 5'd6, 5'd9, 4'b0100);
        s.outReady = 1'b0;
        applyStimulus(s);
        s = issueStim(5'd7, 5'd6, 5'd10, 4'b0101);
        s.outReady = 1'b0; s.flush = 1'b1;
        s.wbEn = 1'b1; s.wbRd = 5'd9; s.wbData = 64'h99;
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(issueStim(5'd9, 5'd0, 5'd11, 4'b0000));
        applyStimulus(idleStim());

        // Reset in the middle of a stall
        applyStimulus(wbStim(5'd3, 64'h55));
        s = issueStim(5'd3, 5'd5, 5'd12, 4'b0000);
        s.outReady = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        s.reset = 1'b1;
        applyStimulus(s);
        checkOutput("reset_mid_stall");
        applyStimulus(issueStim(5'd3, 5'd3, 5'd13, 4'b0000));
        applyStimulus(idleStim());

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            s.inValid  = ($urandom_range(0, 3) != 0);
            s.wbEn     = ($urandom_range(0, 1) != 0);
            s.wbRd     = 5'($urandom_range(0, 31));
            s.wbData   = {$urandom, $urandom};
            s.rs1      = ($urandom_range(0, 3) == 0) ? s.wbRd : 5'($urandom_range(0, 31));
            s.rs2      = ($urandom_range(0, 3) == 0) ? s.wbRd : 5'($urandom_range(0, 31));
            s.rd       = 5'($urandom_range(0, 31));
            s.op       = 4'($urandom_range(0, 15));
            s.imm      = {$urandom, $urandom};
            s.useImm   = ($urandom_range(0, 2) == 0);
            s.outReady = ($urandom_range(0, 9) < 7);
            s.flush    = ($urandom_range(0, 19) == 0);
            s.reset    = ($urandom_range(0, 99) == 0);
            applyStimulus(s);
        end

        for (int i = 0; i < 4; i++) applyStimulus(idleStim());
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
